// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a byte stream (16-bit LE word count + LE 32-bit words) into RAM writes.
// Latency: one cycle from acceptance of a word's 4th byte to its we pulse; done rises one cycle after the last we.
// Backpressure: none while loading (byte_ready=1 in HDR0/HDR1/DATA); byte_ready=0 in IDLE/DONE/ERR.
//
// Ports:
//   clk, reset_n        single rising-edge clock, synchronous active-low reset
//   start, abort        load control: start a new load / abandon the current one
//   byte_valid/_data    incoming stream byte, byte_ready accepts it
//   we, wa, wd          registered RAM write port (wa word-aligned byte address)
//   cpu_reset           holds the processor in reset while a load is pending or failed
//   done, err           status levels of the last load
//   word_count          words written so far in the current/last load

module imem_loader #(
  parameter int DEPTH = 128,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          we,
  output logic [31:0]   wa,
  output logic [31:0]   wd,
  output logic          cpu_reset,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state_q, state_d;
  logic [CW-1:0] n_q, n_d;        // header word count
  logic [1:0]    lane_q, lane_d;  // byte lane of the next data byte
  logic [23:0]   asm_q, asm_d;    // lanes 0..2 of the word being assembled
  logic          we_q, we_d;
  logic [31:0]   wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic [CW-1:0] wc_q, wc_d;

  logic          loading;
  logic          accept;
  logic [CW-1:0] hdr_full;
  logic          last_written;

  // Loading states are the only ones that take bytes.
  assign loading  = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
  assign accept   = byte_valid && loading;

  // Complete header as it will be once the HDR1 byte lands.
  assign hdr_full = {byte_data, n_q[7:0]};

  // The final write has just been presented on the RAM port; finishing one
  // cycle later keeps done (and cpu_reset release) strictly after the last we.
  assign last_written = we_q && (wc_q == n_q);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    wc_d    = wc_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR0;
          wc_d    = '0;
          lane_d  = 2'd0;
          n_d     = '0;
          asm_d   = '0;
        end
      end

      S_HDR0: begin
        if (abort) begin
          state_d = S_ERR;
        end else if (accept) begin
          n_d[7:0] = byte_data;
          state_d  = S_HDR1;
        end
      end

      S_HDR1: begin
        if (abort) begin
          state_d = S_ERR;
        end else if (accept) begin
          n_d[15:8] = byte_data;
          if (hdr_full == '0) begin
            state_d = S_DONE;
          end else if (hdr_full > DEPTH_C) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (abort) begin
          // Partial word is dropped; a write already registered still goes out.
          state_d = S_ERR;
          lane_d  = 2'd0;
        end else if (last_written) begin
          state_d = S_DONE;
        end else if (accept) begin
          case (lane_q)
            2'd0: begin
              asm_d[7:0] = byte_data;
              lane_d     = 2'd1;
            end
            2'd1: begin
              asm_d[15:8] = byte_data;
              lane_d      = 2'd2;
            end
            2'd2: begin
              asm_d[23:16] = byte_data;
              lane_d       = 2'd3;
            end
            default: begin
              // Lane 3 comes straight from the bus so the write issues next cycle.
              we_d   = 1'b1;
              wd_d   = {byte_data, asm_q};
              wa_d   = 32'({wc_q, 2'b00});
              wc_d   = wc_q + 1'b1;
              lane_d = 2'd0;
            end
          endcase
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      lane_q  <= 2'd0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      wc_q    <= wc_d;
    end
  end

  assign byte_ready = loading;
  assign we         = we_q;
  assign wa         = wa_q;
  assign wd         = wd_q;
  assign word_count = wc_q;
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  // A failed load keeps the processor held; only IDLE and DONE release it.
  assign cpu_reset  = loading || (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header/data streams with hand-built expected RAM writes.
// Writes are logged on the falling edge; status outputs are sampled on the falling edge.
// Inputs are driven on the falling edge so every handshake resolves on the next rising edge.

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        cpu_reset;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  imem_loader #(.DEPTH(128), .CW(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write log and spacing monitor
  logic [31:0] log_wa[$];
  logic [31:0] log_wd[$];
  int cyc = 0;
  int last_we_cyc = 0;
  bit have_last = 0;
  int bad_gap = 0;
  logic done_at_we = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (we) begin
      log_wa.push_back(wa);
      log_wd.push_back(wd);
      if (have_last && (cyc - last_we_cyc) != 4) bad_gap++;
      last_we_cyc = cyc;
      have_last   = 1'b1;
      done_at_we  = done;
    end
  end

  task automatic clr_log();
    log_wa.delete();
    log_wd.delete();
    have_last = 1'b0;
    bad_gap   = 0;
  endtask

  // Stream construction and driving
  logic [7:0] stream[$];
  int rdy_miss = 0;

  task automatic push_word(input logic [31:0] w);
    stream.push_back(w[7:0]);
    stream.push_back(w[15:8]);
    stream.push_back(w[23:16]);
    stream.push_back(w[31:24]);
  endtask

  task automatic push_hdr(input logic [15:0] n);
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
  endtask

  task automatic send_stream(input int gap_pct, input int start_at);
    rdy_miss = 0;
    for (int i = 0; i < stream.size(); i++) begin
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = stream[i];
      start      = (i == start_at);
      if (!byte_ready) rdy_miss++;
      @(posedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] pat(input int i, input logic [7:0] salt);
    logic [7:0] b;
    b = 8'(i);
    return {salt ^ b, b, ~b, salt};
  endfunction

  int mism;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset state
    wait_cyc(2);
    chk("por_ready", byte_ready, 0);
    chk("por_cpu_reset", cpu_reset, 0);
    chk("por_done", done, 0);
    chk("por_err", err, 0);
    reset_n = 1'b1;

    // 1: reset in the middle of DATA
    clr_log();
    pulse_start();
    push_hdr(16'd2);
    push_word(32'h11223344);
    stream.push_back(8'hAA);
    stream.push_back(8'hBB);
    send_stream(0, -1);
    chk("r_pre_wd", wd, 32'h11223344);
    chk("r_pre_wc", word_count, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("r_ready", byte_ready, 0);
    chk("r_we", we, 0);
    chk("r_wa", wa, 0);
    chk("r_wd", wd, 0);
    chk("r_cpu_reset", cpu_reset, 0);
    chk("r_done", done, 0);
    chk("r_err", err, 0);
    chk("r_wc", word_count, 0);
    wait_cyc(3);
    chk("r_writes", log_wa.size(), 1);

    // 2: small two-word load
    clr_log();
    pulse_start();
    chk("s_cpu_reset_load", cpu_reset, 1);
    push_hdr(16'd2);
    push_word(32'hE3A09000);
    push_word(32'hE3A000C8);
    send_stream(0, -1);
    wait_cyc(3);
    chk("s_writes", log_wa.size(), 2);
    if (log_wa.size() == 2) begin
      chk("s_wa0", log_wa[0], 32'h0);
      chk("s_wd0", log_wd[0], 32'hE3A09000);
      chk("s_wa1", log_wa[1], 32'h4);
      chk("s_wd1", log_wd[1], 32'hE3A000C8);
    end
    chk("s_done", done, 1);
    chk("s_cpu_reset", cpu_reset, 0);
    chk("s_wc", word_count, 2);
    chk("s_done_after_we", done_at_we, 0);

    // 3: zero and oversize headers
    clr_log();
    pulse_start();
    push_hdr(16'd0);
    send_stream(0, -1);
    wait_cyc(2);
    chk("z_done", done, 1);
    chk("z_err", err, 0);
    chk("z_cpu_reset", cpu_reset, 0);
    chk("z_wc", word_count, 0);
    pulse_start();
    push_hdr(16'd129);
    send_stream(0, -1);
    wait_cyc(2);
    chk("o_err", err, 1);
    chk("o_done", done, 0);
    chk("o_cpu_reset", cpu_reset, 1);
    chk("o_ready", byte_ready, 0);
    chk("zo_writes", log_wa.size(), 0);

    // 4: full depth, back-to-back bytes
    clr_log();
    pulse_start();
    push_hdr(16'd128);
    for (int i = 0; i < 128; i++) push_word(pat(i, 8'hA5));
    send_stream(0, -1);
    chk("f_rdy_miss", rdy_miss, 0);
    wait_cyc(3);
    chk("f_writes", log_wa.size(), 128);
    chk("f_gap", bad_gap, 0);
    mism = 0;
    for (int i = 0; i < log_wa.size(); i++) begin
      if (log_wa[i] !== 32'(i * 4) || log_wd[i] !== pat(i, 8'hA5)) mism++;
    end
    chk("f_data_mism", mism, 0);
    if (log_wa.size() > 0) chk("f_last_wa", log_wa[log_wa.size() - 1], 32'h1FC);
    chk("f_done", done, 1);
    chk("f_wc", word_count, 128);
    chk("f_done_after_we", done_at_we, 0);

    // 5: abort after six data bytes, then a clean one-word load
    clr_log();
    pulse_start();
    push_hdr(16'd3);
    push_word(pat(0, 8'h5A));
    stream.push_back(8'h77);
    stream.push_back(8'h66);
    send_stream(0, -1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("a_err", err, 1);
    chk("a_cpu_reset", cpu_reset, 1);
    wait_cyc(3);
    chk("a_writes", log_wa.size(), 1);
    if (log_wa.size() == 1) begin
      chk("a_wa0", log_wa[0], 32'h0);
      chk("a_wd0", log_wd[0], pat(0, 8'h5A));
    end
    clr_log();
    pulse_start();
    push_hdr(16'd1);
    push_word(32'hCAFEF00D);
    send_stream(0, -1);
    wait_cyc(3);
    chk("a2_done", done, 1);
    chk("a2_err", err, 0);
    chk("a2_wc", word_count, 1);
    chk("a2_writes", log_wa.size(), 1);
    if (log_wa.size() == 1) chk("a2_wd", log_wd[0], 32'hCAFEF00D);

    // 6: bytes in IDLE ignored, gapped load with a stray start in DATA
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clr_log();
    stream.delete();
    for (int i = 0; i < 6; i++) stream.push_back(8'(8'h30 + i));
    send_stream(0, -1);
    wait_cyc(2);
    chk("i_rdy_miss", rdy_miss, 6);
    chk("i_cpu_reset", cpu_reset, 0);
    chk("i_wc", word_count, 0);
    chk("i_writes", log_wa.size(), 0);
    pulse_start();
    push_hdr(16'd5);
    for (int i = 0; i < 5; i++) push_word(pat(i + 40, 8'h3C));
    send_stream(40, 9);
    chk("g_rdy_miss", rdy_miss, 0);
    wait_cyc(3);
    chk("g_writes", log_wa.size(), 5);
    mism = 0;
    for (int i = 0; i < log_wa.size(); i++) begin
      if (log_wa[i] !== 32'(i * 4) || log_wd[i] !== pat(i + 40, 8'h3C)) mism++;
    end
    chk("g_data_mism", mism, 0);
    chk("g_done", done, 1);
    chk("g_wc", word_count, 5);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
